// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-format encodings, size constants and the
// frame length helper used by both the TX arbiter and the RX side.
package uart_pkg;

  localparam int UART_DATA_WIDTH     = 8;
  localparam int UART_MAX_FRAME_BITS = 12;

  typedef enum logic {DATA_BITS_7 = 1'b0, DATA_BITS_8 = 1'b1} data_bits_e;
  typedef enum logic {PARITY_OFF  = 1'b0, PARITY_ON   = 1'b1} parity_en_e;
  typedef enum logic {PARITY_EVEN = 1'b0, PARITY_ODD  = 1'b1} parity_sel_e;
  typedef enum logic {STOP_BITS_1 = 1'b0, STOP_BITS_2 = 1'b1} stop_bits_e;

  // Arbiter slot sequencer states
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_STROBE, ST_WAIT} arb_state_e;

  // Bit times on the line for one frame: start + data + parity + stop
  function automatic logic [4:0] frame_bits(input logic seven_bit,
                                            input logic parity_en,
                                            input logic stop_bit);
    logic [4:0] n;
    n = 5'd1;
    n = n + ((data_bits_e'(seven_bit) == DATA_BITS_8) ? 5'd8 : 5'd7);
    if (parity_en_e'(parity_en) == PARITY_ON) n = n + 5'd1;
    n = n + ((stop_bits_e'(stop_bit) == STOP_BITS_2) ? 5'd2 : 5'd1);
    return n;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/core bundle for the shared UART TX arbiter.
// slave  : arbiter view (takes requests and format, drives the core side)
// master : requester/environment view
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  import uart_pkg::*;

  logic [NUM_REQ-1:0]                 iREQ;
  logic [NUM_REQ*UART_DATA_WIDTH-1:0] iDATA;
  logic                               iSEVEN_BIT;
  logic                               iPARITY_EN;
  logic                               iODD_PARITY;
  logic                               iSTOP_BIT;

  logic [NUM_REQ-1:0]                 oACK;
  logic [2:0]                         oGRANT_ID;
  logic                               oBUSY;
  logic                               oDE;
  logic [UART_DATA_WIDTH-1:0]         oDATA;
  logic                               oSEVEN_BIT;
  logic                               oPARITY_EN;
  logic                               oODD_PARITY;
  logic                               oSTOP_BIT;

  modport slave (
    input  iREQ, iDATA, iSEVEN_BIT, iPARITY_EN, iODD_PARITY, iSTOP_BIT,
    output oACK, oGRANT_ID, oBUSY, oDE, oDATA,
           oSEVEN_BIT, oPARITY_EN, oODD_PARITY, oSTOP_BIT
  );

  modport master (
    output iREQ, iDATA, iSEVEN_BIT, iPARITY_EN, iODD_PARITY, iSTOP_BIT,
    input  oACK, oGRANT_ID, oBUSY, oDE, oDATA,
           oSEVEN_BIT, oPARITY_EN, oODD_PARITY, oSTOP_BIT
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NUM_REQ. Reusable for any shared resource.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [2:0]         grant_idx,
  output logic               any_req
);

  logic [NUM_REQ-1:0] req_rot;
  logic [2:0]         offset;
  logic [3:0]         idx_sum;

  // Rotate so that bit 0 is the requester the pointer currently favours
  assign req_rot = NUM_REQ'({req, req} >> ptr);
  assign any_req = |req;

  // Lowest set bit of the rotated vector is the distance from the pointer
  always_comb begin
    offset = 3'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = 3'(k);
    end
  end

  assign idx_sum   = {1'b0, ptr} + {1'b0, offset};
  assign grant_idx = (idx_sum >= 4'(NUM_REQ)) ? 3'(idx_sum - 4'(NUM_REQ))
                                              : idx_sum[2:0];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign grant_oh[gi] = any_req && (grant_idx == 3'(gi));
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART TX core. Each grant latches a byte and
// the frame format, strobes DE for two bit times and then holds everything
// stable for a slot sized from the latched format, since the core offers
// no busy indication of its own.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 3
) (
  input logic              CLK,
  input logic              RST_N,
  uart_tx_arbiter_if.slave bus
);

  arb_state_e             state_q, state_d;
  logic [2:0]             winner_q, winner_d;
  logic [NUM_REQ-1:0]     winner_oh_q, winner_oh_d;
  logic [2:0]             ptr_q, ptr_d;
  logic [4:0]             cnt_q, cnt_d;
  logic                   strobe2_q, strobe2_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic [2:0]             gid_q, gid_d;
  logic                   busy_q, busy_d;
  logic                   de_q, de_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   seven_q, seven_d;
  logic                   par_q, par_d;
  logic                   odd_q, odd_d;
  logic                   stop_q, stop_d;

  logic [NUM_REQ-1:0]     rr_oh;
  logic [2:0]             rr_idx;
  logic                   rr_any;
  logic [3:0]             winner_inc;
  logic [2:0]             ptr_next;
  logic [4:0]             slot_m1;
  logic [DATA_WIDTH-1:0]  byte_sel;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (bus.iREQ),
    .ptr       (ptr_q),
    .grant_oh  (rr_oh),
    .grant_idx (rr_idx),
    .any_req   (rr_any)
  );

  assign winner_inc = {1'b0, winner_q} + 4'd1;
  assign ptr_next   = (winner_inc >= 4'(NUM_REQ)) ? 3'd0 : winner_inc[2:0];
  // Slot covers the whole frame plus DE detect latency and inter-frame idle
  assign slot_m1    = frame_bits(bus.iSEVEN_BIT, bus.iPARITY_EN, bus.iSTOP_BIT)
                      + 5'(GAP_CYCLES) - 5'd1;
  assign byte_sel   = DATA_WIDTH'(bus.iDATA >> {winner_q, 3'b000});

  // Next-state and registered-output logic for the grant/strobe/slot sequence
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    winner_oh_d = winner_oh_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    strobe2_d   = strobe2_q;
    ack_d       = '0;
    gid_d       = gid_q;
    busy_d      = busy_q;
    de_d        = de_q;
    data_d      = data_q;
    seven_d     = seven_q;
    par_d       = par_q;
    odd_d       = odd_q;
    stop_d      = stop_q;
    case (state_q)
      ST_IDLE: begin
        if (rr_any) begin
          winner_d    = rr_idx;
          winner_oh_d = rr_oh;
          state_d     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        data_d    = byte_sel;
        seven_d   = bus.iSEVEN_BIT;
        par_d     = bus.iPARITY_EN;
        odd_d     = bus.iODD_PARITY;
        stop_d    = bus.iSTOP_BIT;
        ack_d     = winner_oh_q;
        gid_d     = winner_q;
        busy_d    = 1'b1;
        de_d      = 1'b1;
        ptr_d     = ptr_next;
        cnt_d     = slot_m1;
        strobe2_d = 1'b0;
        state_d   = ST_STROBE;
      end
      ST_STROBE: begin
        cnt_d = cnt_q - 5'd1;
        if (strobe2_q) begin
          de_d    = 1'b0;
          state_d = ST_WAIT;
        end else begin
          strobe2_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 5'd0) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset also drops DE mid-frame at once
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      winner_q    <= 3'd0;
      winner_oh_q <= '0;
      ptr_q       <= 3'd0;
      cnt_q       <= 5'd0;
      strobe2_q   <= 1'b0;
      ack_q       <= '0;
      gid_q       <= 3'd0;
      busy_q      <= 1'b0;
      de_q        <= 1'b0;
      data_q      <= '1;
      seven_q     <= 1'b1;
      par_q       <= 1'b0;
      odd_q       <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      winner_oh_q <= winner_oh_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      strobe2_q   <= strobe2_d;
      ack_q       <= ack_d;
      gid_q       <= gid_d;
      busy_q      <= busy_d;
      de_q        <= de_d;
      data_q      <= data_d;
      seven_q     <= seven_d;
      par_q       <= par_d;
      odd_q       <= odd_d;
      stop_q      <= stop_d;
    end
  end

  assign bus.oACK        = ack_q;
  assign bus.oGRANT_ID   = gid_q;
  assign bus.oBUSY       = busy_q;
  assign bus.oDE         = de_q;
  assign bus.oDATA       = data_q;
  assign bus.oSEVEN_BIT  = seven_q;
  assign bus.oPARITY_EN  = par_q;
  assign bus.oODD_PARITY = odd_q;
  assign bus.oSTOP_BIT   = stop_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-cycle stimulus and expected outputs are
// planned up front by a slot-level model, then replayed against the DUT,
// followed by a directed asynchronous-reset scenario.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int GAP  = 3;
  localparam int NCYC = 2000;

  logic CLK = 1'b0;
  logic RST_N;

  always #5 CLK = ~CLK;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(8), .GAP_CYCLES(GAP)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  // planned stimulus per cycle
  logic [N-1:0]   st_req  [NCYC];
  logic [8*N-1:0] st_data [NCYC];
  logic [3:0]     st_fmt  [NCYC];   // {seven, parity_en, odd, stop}
  // expected outputs per cycle
  logic [N-1:0]   ex_ack  [NCYC];
  bit             ex_de   [NCYC];
  bit             ex_busy [NCYC];
  logic [7:0]     ex_data [NCYC];
  logic [3:0]     ex_fmt  [NCYC];
  logic [2:0]     ex_gid  [NCYC];

  int n_checks  = 0;
  int n_pass    = 0;
  int cur_cycle = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cur_cycle, got, exp);
  endtask

  // Slot length in bit times: start, data, parity, stop(s), plus the gap
  function automatic int slot_len(input logic [3:0] fmt);
    return 1 + (fmt[3] ? 8 : 7) + (fmt[2] ? 1 : 0) + (fmt[0] ? 2 : 1) + GAP;
  endfunction

  // Walk time slot by slot: when the arbiter is free it looks at the request
  // vector once; a grant occupies GRANT, then SLOT cycles of busy time.
  task automatic build_model();
    int         next_idle;
    int         gcyc;
    int         gw;
    int         ptr;
    int         s;
    int         drop_at [N];
    bit         pend    [N];
    logic [3:0] fmt_cur;
    logic [N-1:0]   r;
    logic [8*N-1:0] d;
    next_idle = 0; gcyc = -1; gw = 0; ptr = 0; fmt_cur = 4'b1000;
    for (int i = 0; i < N; i++) begin drop_at[i] = -1; pend[i] = 1'b0; end
    for (int c = 0; c < NCYC; c++) begin
      ex_ack[c] = '0; ex_de[c] = 1'b0; ex_busy[c] = 1'b0;
      ex_data[c] = 8'hFF; ex_fmt[c] = 4'b1000; ex_gid[c] = 3'd0;
    end
    for (int c = 0; c < NCYC; c++) begin
      for (int i = 0; i < N; i++) if (drop_at[i] == c) pend[i] = 1'b0;
      r = '0;
      if (c < 40) begin
        // single request A5 8N1, then byte/format change mid-slot, req1 glitch
        d       = {8'h13, 8'h12, 8'h11, (c < 6) ? 8'hA5 : 8'h5A};
        fmt_cur = (c < 6) ? 4'b1000 : 4'b0000;
        if (c == 2) pend[0] = 1'b1;
        for (int i = 0; i < N; i++) r[i] = pend[i];
        if (c == 10) r[1] = 1'b1;
      end else if (c < 200) begin
        // all requesters held high: 8N1 first, then 7E2
        d       = {8'h13, 8'h12, 8'h11, 8'h10};
        fmt_cur = (c < 120) ? 4'b1000 : 4'b0101;
        for (int i = 0; i < N; i++) pend[i] = 1'b1;
        for (int i = 0; i < N; i++) r[i] = pend[i];
      end else begin
        for (int i = 0; i < N; i++) d[8*i +: 8] = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) fmt_cur = 4'($urandom_range(0, 15));
        for (int i = 0; i < N; i++)
          if (!pend[i] && $urandom_range(0, 7) == 0) pend[i] = 1'b1;
        for (int i = 0; i < N; i++) r[i] = pend[i];
        if ($urandom_range(0, 31) == 0) r[$urandom_range(0, N - 1)] = 1'b1;
      end
      st_req[c] = r; st_data[c] = d; st_fmt[c] = fmt_cur;

      if (c == gcyc) begin
        s = slot_len(fmt_cur);
        for (int t = c + 1; t <= c + s && t < NCYC; t++) ex_busy[t] = 1'b1;
        if (c + 1 < NCYC) begin ex_ack[c + 1] = N'(1 << gw); ex_de[c + 1] = 1'b1; end
        if (c + 2 < NCYC) ex_de[c + 2] = 1'b1;
        for (int t = c + 1; t < NCYC; t++) begin
          ex_data[t] = d[8*gw +: 8]; ex_fmt[t] = fmt_cur; ex_gid[t] = 3'(gw);
        end
        next_idle   = c + 1 + s;
        drop_at[gw] = c + 2;
      end

      if (c == next_idle) begin
        if (r != '0) begin
          for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) begin gw = (ptr + k) % N; break; end
          end
          ptr  = (gw + 1) % N;
          gcyc = c + 1;
        end else begin
          next_idle = c + 1;
        end
      end
    end
  endtask

  task automatic check_outputs(input string pfx, input int c);
    check({pfx, "_ack"},  32'(bus.oACK), 32'(ex_ack[c]));
    check({pfx, "_de"},   32'(bus.oDE), 32'(ex_de[c]));
    check({pfx, "_busy"}, 32'(bus.oBUSY), 32'(ex_busy[c]));
    check({pfx, "_data"}, 32'(bus.oDATA), 32'(ex_data[c]));
    check({pfx, "_fmt"},  32'({bus.oSEVEN_BIT, bus.oPARITY_EN, bus.oODD_PARITY, bus.oSTOP_BIT}),
          32'(ex_fmt[c]));
    check({pfx, "_gid"},  32'(bus.oGRANT_ID), 32'(ex_gid[c]));
  endtask

  initial begin
    bit found;
    RST_N = 1'b0;
    bus.iREQ = '0; bus.iDATA = '0;
    bus.iSEVEN_BIT = 1'b1; bus.iPARITY_EN = 1'b0; bus.iODD_PARITY = 1'b0; bus.iSTOP_BIT = 1'b0;
    build_model();

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_ack", 32'(bus.oACK), 32'd0);
    check("rst_gid", 32'(bus.oGRANT_ID), 32'd0);
    check("rst_busy", 32'(bus.oBUSY), 32'd0);
    check("rst_de", 32'(bus.oDE), 32'd0);
    check("rst_data", 32'(bus.oDATA), 32'hFF);
    check("rst_fmt", 32'({bus.oSEVEN_BIT, bus.oPARITY_EN, bus.oODD_PARITY, bus.oSTOP_BIT}), 32'h8);
    RST_N = 1'b1;

    for (int c = 0; c < NCYC; c++) begin
      @(posedge CLK);
      #1;
      bus.iREQ  = st_req[c];
      bus.iDATA = st_data[c];
      {bus.iSEVEN_BIT, bus.iPARITY_EN, bus.iODD_PARITY, bus.iSTOP_BIT} = st_fmt[c];
      @(negedge CLK);
      cur_cycle = c;
      if (bus.oACK != '0 || ex_ack[c] != '0)
        $display("cycle %0d: ack=%b grant_id=%0d data=%02h fmt=%b (model ack=%b id=%0d data=%02h)",
                 c, bus.oACK, bus.oGRANT_ID, bus.oDATA,
                 {bus.oSEVEN_BIT, bus.oPARITY_EN, bus.oODD_PARITY, bus.oSTOP_BIT},
                 ex_ack[c], ex_gid[c], ex_data[c]);
      check_outputs("run", c);
    end

    // Drain: stop requesting and let any slot in flight finish
    @(posedge CLK); #1; bus.iREQ = '0;
    repeat (2) @(negedge CLK);
    for (int k = 0; k < 40; k++) begin
      if (!bus.oBUSY) break;
      @(negedge CLK);
    end
    cur_cycle = -2;
    check("drain_busy", 32'(bus.oBUSY), 32'd0);

    // req2 from idle: ACK two cycles after the request appears
    @(posedge CLK); #1; bus.iREQ = 4'b0100;
    bus.iDATA = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int k = 0; k <= 2; k++) begin
      @(negedge CLK);
      cur_cycle = -10 - k;
      check("lat_ack", 32'(bus.oACK), (k == 2) ? 32'h4 : 32'h0);
    end
    $display("directed: ack=%b grant_id=%0d data=%02h de=%b", bus.oACK, bus.oGRANT_ID, bus.oDATA, bus.oDE);
    check("strobe_de", 32'(bus.oDE), 32'd1);
    check("strobe_data", 32'(bus.oDATA), 32'h33);

    // Reset in the middle of the strobe: outputs clear without a clock edge
    RST_N = 1'b0;
    bus.iREQ = 4'b1100;
    #1;
    cur_cycle = -20;
    check("arst_de", 32'(bus.oDE), 32'd0);
    check("arst_busy", 32'(bus.oBUSY), 32'd0);
    check("arst_ack", 32'(bus.oACK), 32'd0);
    check("arst_data", 32'(bus.oDATA), 32'hFF);
    @(negedge CLK);
    RST_N = 1'b1;

    // Pointer is back at 0, so req2 wins over req3 (a kept pointer would pick 3)
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (bus.oACK != '0) begin found = 1'b1; break; end
    end
    cur_cycle = -30;
    $display("after reset: found=%0d ack=%b grant_id=%0d data=%02h", found, bus.oACK, bus.oGRANT_ID, bus.oDATA);
    check("post_rst_ack", 32'(bus.oACK), 32'h4);
    check("post_rst_gid", 32'(bus.oGRANT_ID), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART TX core among NUM_REQ byte requesters using round-robin arbitration.
- Captures the granted byte and the frame-format config, raises the core's DE strobe, and holds data and config stable for a full frame slot before the next grant.
- The core has no busy output, so frame length is computed from the latched format.
- Sits between requester blocks (gaze-coordinate packer, status reporter, etc.) and the UART TX core.
- Runs on the core's bit clock: one CLK cycle equals one bit time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width, fixed at 8
GAP_CYCLES, 3, extra slot cycles covering DE edge-detect latency, core state entry and inter-frame idle (1..15)

Ports:
CLK  input  1  bit-rate clock, shared with the TX core
RST_N  input  1  reset (see Behaviour)
iREQ  input  NUM_REQ  level request per requester; held until its oACK
iDATA  input  NUM_REQ*8  byte per requester; requester i uses bits [8i+7:8i]
iSEVEN_BIT  input  1  format: 0=7 data bits, 1=8 data bits
iPARITY_EN  input  1  parity enable
iODD_PARITY  input  1  odd parity select
iSTOP_BIT  input  1  0=1 stop bit, 1=2 stop bits
oACK  output  NUM_REQ  one-cycle pulse on the granted requester's bit
oGRANT_ID  output  3  index of last granted requester
oBUSY  output  1  high from grant to end of slot
oDE  output  1  to core DE
oDATA  output  8  to core data
oSEVEN_BIT, oPARITY_EN, oODD_PARITY, oSTOP_BIT  output  1 each  latched format, to core

Behaviour:
- One clock, CLK. Reset is asynchronous and active-low on RST_N. All state registers clear on reset.
- Reset values:
  - oACK=0, oGRANT_ID=0, oBUSY=0, oDE=0, oDATA=8'hFF.
  - Format outputs: oSEVEN_BIT=1, oPARITY_EN=0, oODD_PARITY=0, oSTOP_BIT=0.
  - Round-robin pointer = 0, slot counter = 0.
- States: IDLE, GRANT, STROBE, WAIT.
- IDLE:
  - If any iREQ bit is set, choose the first set bit searching from pointer upward, with modulo NUM_REQ wrap.
  - Go to GRANT.
  - Outputs stay idle.
- GRANT (1 cycle):
  - Register winner byte into oDATA.
  - Latch the four format inputs into the format outputs.
  - Pulse oACK[winner]; oGRANT_ID=winner; oBUSY=1.
  - Pointer = winner+1, modulo NUM_REQ.
  - Load the slot counter with SLOT-1, where:
    - SLOT = 1 + (iSEVEN_BIT ? 8 : 7) + iPARITY_EN + (iSTOP_BIT ? 2 : 1) + GAP_CYCLES.
    - Counter width is 5 bits; max SLOT = 27.
  - Go to STROBE.
- STROBE (2 cycles):
  - oDE=1 for exactly 2 cycles, starting the cycle after GRANT.
  - Counter decrements every cycle after GRANT.
- WAIT:
  - oDE=0; counter decrements.
  - At counter==0 go to IDLE with oBUSY=0.
- Latency and frame spacing:
  - Request-to-ACK latency: 2 cycles from the iREQ rising edge, when the arbiter is idle.
  - Minimum grant-to-grant spacing: SLOT+2 cycles (slot + IDLE + GRANT).
  - oDE therefore has at least GAP_CYCLES+1 low cycles between strobes.
- Stability during a slot: oDATA and the format outputs are held constant from GRANT through the end of WAIT.
  - Format input changes mid-slot apply only to the next grant.
- Requests:
  - A requester still asserting iREQ after its ACK is treated as a new request. It is granted again only when round-robin order reaches it.
  - Requests arriving during a slot are pending, not lost. They are evaluated in IDLE.
- Simultaneous requests: strict round-robin from the pointer. With all bits set, grants run 0,1,2,3,0,...
- Dropped request: a request deasserted before GRANT is ignored. The arbiter evaluates iREQ only in IDLE.
- Reset mid-slot: oDE drops immediately and the core is left to its own reset. No ACK is reissued.
- Unused iREQ bits above NUM_REQ do not exist. oGRANT_ID is zero-extended.

Decomposition:
- Shared package uart_pkg:
  - Data-bit, parity and stop-bit encodings.
  - Constants UART_DATA_WIDTH=8 and UART_MAX_FRAME_BITS=12.
  - Function frame_bits(seven_bit, parity_en, stop_bit), shared with the RX side.
- One natural sub-module: rr_arbiter.
  - Inputs: request vector, pointer. Outputs: one-hot winner, binary index, any_req.
  - Combinational, reusable by other shared resources.

Test Plan:
- Single request, req0 with byte 8'hA5, 8N1, GAP 3 (SLOT 13):
  - ACK[0] 2 cycles after req.
  - oDE high 2 cycles; oDATA=8'hA5 held 13 cycles.
  - oBUSY low after slot. Core TX line shows 0,1,0,1,0,0,1,0,1,1.
- All 4 requests held high (bytes 8'h10/8'h11/8'h12/8'h13):
  - Grants in order 0,1,2,3,0.
  - Consecutive ACKs spaced 15 cycles apart.
- 7E2 format (iSEVEN_BIT=0, iPARITY_EN=1, iODD_PARITY=0, iSTOP_BIT=1), GAP 3:
  - SLOT = 1+7+1+2+3 = 14; next grant spacing is 16 cycles.
  - Format outputs latched at GRANT.
- Change iSEVEN_BIT and iDATA of the granted requester mid-slot:
  - oDATA and oSEVEN_BIT unchanged until the next GRANT.
- Assert RST_N low during STROBE:
  - oDE, oBUSY and oACK go 0 asynchronously; oDATA=8'hFF.
  - After release, a pending req2 is granted first, since the pointer resets to 0 and no lower bit is set.
- req1 pulses for 1 cycle during a slot and drops before IDLE:
  - No ACK issued to requester 1.
